// File: rtl/alu_slice_exec.sv
// Multi-cycle ALU: processes operands one SLICE-bit chunk per cycle, LSB first,
// carrying between slices, and reports result/zero/err through valid/ready.
module alu_slice_exec #(
   parameter int WIDTH = 32,
   parameter int SLICE = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start_valid,
   output logic             start_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [2:0]       alucontrol,
   output logic             result_valid,
   input  logic             result_ready,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             err,
   output logic [1:0]       dbg_state
);

   // Handshake: a transfer happens on a rising edge where valid and ready are
   // both high; valid holds with stable payload until ready is seen.

   localparam int NS = WIDTH / SLICE;
   localparam int CW = (NS > 1) ? $clog2(NS) : 1;
   localparam logic [CW-1:0] LAST = CW'(NS - 1);
   localparam logic [WIDTH-1:0] MASK = WIDTH'({SLICE{1'b1}});

   localparam logic [2:0] OP_AND = 3'b000;
   localparam logic [2:0] OP_OR  = 3'b001;
   localparam logic [2:0] OP_ADD = 3'b010;
   localparam logic [2:0] OP_SUB = 3'b110;
   localparam logic [2:0] OP_SLT = 3'b111;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t state_q, state_d;

   logic [WIDTH-1:0] a_q, b_q, acc_q, result_q;
   logic [2:0]       op_q;
   logic             legal_q, sub_q, carry_q, zero_q, err_q;
   logic [CW-1:0]    cnt_q;

   logic [31:0]      base;
   logic [SLICE-1:0] a_k, b_k, bx_k, sum_k, slice_k;
   logic             cout_k, v_k;
   logic [WIDTH-1:0] acc_d, final_d;
   logic             last_slice;

   function automatic logic is_legal(input logic [2:0] op);
      case (op)
         OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT: is_legal = 1'b1;
         default:                               is_legal = 1'b0;
      endcase
   endfunction

   function automatic logic is_sub(input logic [2:0] op);
      case (op)
         OP_SUB, OP_SLT: is_sub = 1'b1;
         default:        is_sub = 1'b0;
      endcase
   endfunction

   assign start_ready  = (state_q == IDLE);
   assign result_valid = (state_q == DONE);
   assign result       = result_q;
   assign zero         = zero_q;
   assign err          = err_q;
   assign dbg_state    = state_q;
   assign last_slice   = (cnt_q == LAST);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start_valid) state_d = RUN;
         RUN:     if (last_slice) state_d = DONE;
         DONE:    if (result_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Slice datapath; shifts rather than indexed part-selects keep it width-clean.
   always_comb begin
      base    = 32'(cnt_q) * 32'(SLICE);
      a_k     = SLICE'(a_q >> base);
      b_k     = SLICE'(b_q >> base);
      bx_k    = sub_q ? ~b_k : b_k;
      {cout_k, sum_k} = {1'b0, a_k} + {1'b0, bx_k} + {{SLICE{1'b0}}, carry_q};
      case (op_q)
         OP_ADD, OP_SUB, OP_SLT: slice_k = sum_k;
         OP_AND:                 slice_k = a_k & b_k;
         OP_OR:                  slice_k = a_k | b_k;
         default:                slice_k = '0;
      endcase
      acc_d = (acc_q & ~(MASK << base)) | (WIDTH'(slice_k) << base);
      // Overflow: carry into the MSB (recovered from the sum bit) vs carry out.
      v_k   = (a_k[SLICE-1] ^ bx_k[SLICE-1] ^ sum_k[SLICE-1]) ^ cout_k;
      final_d = acc_d;
      if (!legal_q)
         final_d = '0;
      else if (op_q == OP_SLT)
         final_d = {{(WIDTH-1){1'b0}}, sum_k[SLICE-1] ^ v_k};
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         a_q      <= '0;
         b_q      <= '0;
         op_q     <= '0;
         legal_q  <= 1'b0;
         sub_q    <= 1'b0;
         carry_q  <= 1'b0;
         cnt_q    <= '0;
         acc_q    <= '0;
         result_q <= '0;
         zero_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start_valid) begin
                  a_q     <= a;
                  b_q     <= b;
                  op_q    <= alucontrol;
                  legal_q <= is_legal(alucontrol);
                  sub_q   <= is_sub(alucontrol);
                  carry_q <= is_sub(alucontrol);
                  cnt_q   <= '0;
                  acc_q   <= '0;
               end
            end
            RUN: begin
               carry_q <= cout_k;
               acc_q   <= acc_d;
               cnt_q   <= cnt_q + CW'(1);
               if (last_slice) begin
                  result_q <= final_d;
                  zero_q   <= (final_d == '0);
                  err_q    <= ~legal_q;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_slice_exec.sv
// Bench for alu_slice_exec: NS=4 and NS=1 instances, directed vectors,
// scoreboard queues filled at accept and drained by a negedge monitor.
module tb_alu_slice_exec;

   localparam int W = 32;
   localparam logic [2:0] AND_C = 3'b000, OR_C = 3'b001, ADD_C = 3'b010,
                          SUB_C = 3'b110, SLT_C = 3'b111, BAD_C = 3'b011;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   logic         start_valid[2], start_ready[2], result_valid[2], result_ready[2];
   logic         zero[2], err[2];
   logic [W-1:0] a[2], b[2], result[2];
   logic [2:0]   alucontrol[2];
   logic [1:0]   dbg_state[2];

   alu_slice_exec #(.WIDTH(32), .SLICE(8)) dut4 (
      .clk(clk), .reset(reset), .start_valid(start_valid[0]), .start_ready(start_ready[0]),
      .a(a[0]), .b(b[0]), .alucontrol(alucontrol[0]), .result_valid(result_valid[0]),
      .result_ready(result_ready[0]), .result(result[0]), .zero(zero[0]), .err(err[0]),
      .dbg_state(dbg_state[0]));

   alu_slice_exec #(.WIDTH(32), .SLICE(32)) dut1 (
      .clk(clk), .reset(reset), .start_valid(start_valid[1]), .start_ready(start_ready[1]),
      .a(a[1]), .b(b[1]), .alucontrol(alucontrol[1]), .result_valid(result_valid[1]),
      .result_ready(result_ready[1]), .result(result[1]), .zero(zero[1]), .err(err[1]),
      .dbg_state(dbg_state[1]));

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [W+1:0] exp_q[2][$];
   int           acc_q[2][$];
   int           passed = 0;
   int           total = 0;

   task automatic check(input string name, input logic [W+1:0] act, input logic [W+1:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic fail(input string name);
      total++;
      $display("FAIL %s", name);
   endtask

   // Monitor: latency on first valid cycle, stability while stalled, data on handshake.
   logic         prev_rv[2] = '{1'b0, 1'b0};
   logic [W+1:0] held[2];

   task automatic monitor(input int i);
      int ns;
      int t;
      logic [W+1:0] got;
      ns  = (i == 0) ? 4 : 1;
      got = {err[i], zero[i], result[i]};
      if (result_valid[i] === 1'b1) begin
         if (!prev_rv[i]) begin
            if (acc_q[i].size() == 0) fail($sformatf("spurious_valid_%0d", i));
            else begin
               t = acc_q[i].pop_front();
               check($sformatf("latency_%0d", i), 34'(cyc - t), 34'(ns));
            end
            held[i] = got;
         end else begin
            check($sformatf("hold_%0d", i), got, held[i]);
            check($sformatf("busy_ready_%0d", i), 34'(start_ready[i]), 34'(0));
         end
         if (result_ready[i]) begin
            if (exp_q[i].size() == 0) fail($sformatf("unexpected_result_%0d", i));
            else check($sformatf("result_%0d", i), got, exp_q[i].pop_front());
         end
      end
      prev_rv[i] = (result_valid[i] === 1'b1);
   endtask

   always @(negedge clk) begin
      for (int i = 0; i < 2; i++) monitor(i);
   end

   task automatic issue(input int i, input logic [2:0] op, input logic [W-1:0] x,
                        input logic [W-1:0] y, input logic [W-1:0] r, input logic e,
                        input logic push);
      bit got;
      int n;
      got = 0;
      n   = 0;
      @(posedge clk); #1;
      a[i] = x; b[i] = y; alucontrol[i] = op; start_valid[i] = 1'b1;
      while (!got && n < 60) begin
         @(negedge clk);
         if (start_ready[i]) begin
            got = 1;
            if (push) begin
               acc_q[i].push_back(cyc + 1);
               exp_q[i].push_back({e, (r == '0), r});
            end
         end
         n++;
      end
      if (!got) fail($sformatf("accept_timeout_%0d", i));
      @(posedge clk); #1;
      start_valid[i] = 1'b0;
      a[i] = ~x; b[i] = ~y;
   endtask

   task automatic wait_done(input int i);
      int n;
      n = 0;
      while (exp_q[i].size() != 0 && n < 100) begin
         @(posedge clk);
         n++;
      end
      if (exp_q[i].size() != 0) fail($sformatf("done_timeout_%0d", i));
      @(posedge clk); #1;
   endtask

   task automatic check_reset_state(input int i, input string tag);
      check({tag, "_start_ready"},  34'(start_ready[i]),  34'(1));
      check({tag, "_result_valid"}, 34'(result_valid[i]), 34'(0));
      check({tag, "_result"},       34'(result[i]),       34'(0));
      check({tag, "_zero"},         34'(zero[i]),         34'(0));
      check({tag, "_err"},          34'(err[i]),          34'(0));
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout");
      $fatal(1, "bench timeout");
   end

   initial begin
      for (int i = 0; i < 2; i++) begin
         start_valid[i] = 1'b0; result_ready[i] = 1'b1;
         a[i] = '0; b[i] = '0; alucontrol[i] = '0;
      end
      reset = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b1;
      @(negedge clk); #1;
      check_reset_state(0, "init4");
      check_reset_state(1, "init1");

      // Directed vectors on the NS=4 instance.
      issue(0, ADD_C, 32'h000000FF, 32'h00000001, 32'h00000100, 1'b0, 1'b1); wait_done(0);
      issue(0, SUB_C, 32'h12345678, 32'h12345678, 32'h00000000, 1'b0, 1'b1); wait_done(0);
      issue(0, SUB_C, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 1'b0, 1'b1); wait_done(0);
      issue(0, SLT_C, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0, 1'b1); wait_done(0);
      issue(0, SLT_C, 32'h7FFFFFFF, 32'h80000000, 32'h00000000, 1'b0, 1'b1); wait_done(0);
      issue(0, SLT_C, 32'h00000005, 32'h00000005, 32'h00000000, 1'b0, 1'b1); wait_done(0);
      issue(0, AND_C, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0, 1'b1); wait_done(0);
      issue(0, OR_C,  32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0, 1'b0, 1'b1); wait_done(0);
      issue(0, BAD_C, 32'h12345678, 32'h9ABCDEF0, 32'h00000000, 1'b1, 1'b1); wait_done(0);

      // Backpressure: second request pending while the first result is stalled.
      result_ready[0] = 1'b0;
      issue(0, ADD_C, 32'd10, 32'd20, 32'd30, 1'b0, 1'b1);
      fork
         issue(0, SUB_C, 32'd100, 32'd1, 32'd99, 1'b0, 1'b1);
         begin
            repeat (10) @(posedge clk);
            #1 result_ready[0] = 1'b1;
         end
      join
      wait_done(0);

      // Reset mid-operation after slice 2; outputs were nonzero beforehand.
      issue(0, OR_C, 32'h0000000F, 32'h000000F0, 32'h000000FF, 1'b0, 1'b1); wait_done(0);
      issue(0, ADD_C, 32'h11111111, 32'h22222222, 32'h0, 1'b0, 1'b0);
      @(posedge clk);
      @(posedge clk);
      #3 reset = 1'b0;
      #1;
      check_reset_state(0, "midrst");
      repeat (2) @(negedge clk);
      reset = 1'b1;
      issue(0, ADD_C, 32'd3, 32'd4, 32'd7, 1'b0, 1'b1); wait_done(0);

      // NS=1 instance.
      issue(1, ADD_C, 32'h000000FF, 32'h00000001, 32'h00000100, 1'b0, 1'b1); wait_done(1);
      issue(1, SLT_C, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0, 1'b1); wait_done(1);
      issue(1, SLT_C, 32'h7FFFFFFF, 32'h80000000, 32'h00000000, 1'b0, 1'b1); wait_done(1);
      issue(1, SLT_C, 32'h00000005, 32'h00000005, 32'h00000000, 1'b0, 1'b1); wait_done(1);

      repeat (3) @(posedge clk);
      check("leftover_accepts_0", 34'(acc_q[0].size()), 34'(0));
      check("leftover_accepts_1", 34'(acc_q[1].size()), 34'(0));
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
